// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: opcodes, loader state encoding, out-of-range read value.
package cpu_bus_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_JMP = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9;
  localparam logic [3:0] OP_ST  = 4'd10;
  localparam logic [3:0] OP_LD  = 4'd11;
  localparam logic [3:0] OP_LI  = 4'd12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    RUN     = 2'd3
  } ld_state_e;

  localparam logic [15:0] ERR_DATA_DEF = 16'h0000;

  function automatic logic in_range(input logic [15:0] addr, input int aw);
    return (addr >> aw) == 16'd0;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_word_ram.sv
// Unified 16-bit word memory: one synchronous write port, two asynchronous read ports.
module word_ram #(
  parameter int AW = 8
) (
  input  logic          CK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr_i,
  input  logic [AW-1:0] raddr_d,
  output logic [15:0]   rdata_i,
  output logic [15:0]   rdata_d
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge CK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_i = mem[raddr_i];
  assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the CPU instruction/data buses with a byte-stream program loader
// that holds the CPU in reset until the image is complete.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int          AW       = 8,
  parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic          CK,
  input  logic          RST,
  input  logic [15:0]   IA,
  output logic [15:0]   ID,
  input  logic [15:0]   DA,
  inout  wire  [15:0]   DD,
  input  logic          RW,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [7:0]    LD_DATA,
  input  logic          LD_LAST,
  output logic          LD_READY,
  output logic          CPU_RST,
  output logic [AW:0]   LD_WORDS,
  output logic          ERR
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  ld_state_e   state, state_nxt;
  logic [AW:0] ptr;
  logic [7:0]  hi;
  logic        cpu_rst, err;
  logic        accept, ld_wr, ld_ovf, cpu_wr, ia_ok, da_ok;
  logic        we;
  logic [AW-1:0] waddr;
  logic [15:0] wdata, ram_i, ram_d, rdata;

  assign ia_ok    = in_range(IA, AW);
  assign da_ok    = in_range(DA, AW);
  assign LD_READY = (state == LOAD_HI || state == LOAD_LO) && !LD_START;
  assign accept   = LD_VALID && LD_READY;
  assign ld_wr    = state == LOAD_LO && accept && ptr != DEPTH;
  assign ld_ovf   = state == LOAD_LO && accept && ptr == DEPTH;
  assign cpu_wr   = state == RUN && !RW && !cpu_rst && da_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (LD_START) state_nxt = LOAD_HI;
      LOAD_HI: if (accept) state_nxt = LOAD_LO;
      LOAD_LO: if (accept) state_nxt = LD_LAST ? RUN : LOAD_HI;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (LD_START) state_nxt = LOAD_HI;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= IDLE;
      cpu_rst <= 1'b1;
      err     <= 1'b0;
      ptr     <= '0;
      hi      <= '0;
    end else begin
      state   <= state_nxt;
      cpu_rst <= state_nxt != RUN;
      if (ld_ovf || (state == RUN && !da_ok)) err <= 1'b1;
      // ptr doubles as the word count; overflowed words leave it saturated at DEPTH
      if (LD_START) ptr <= '0;
      else if (ld_wr) ptr <= ptr + 1'b1;
      if (state == LOAD_HI && accept) hi <= LD_DATA;
    end
  end

  // Loader and CPU writes are mutually exclusive by state; the mux only picks the source.
  always_comb begin
    we    = 1'b0;
    waddr = DA[AW-1:0];
    wdata = DD;
    if (ld_wr) begin
      we    = 1'b1;
      waddr = ptr[AW-1:0];
      wdata = {hi, LD_DATA};
    end else if (cpu_wr) begin
      we = 1'b1;
    end
  end

  word_ram #(.AW(AW)) u_ram (
    .CK      (CK),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_i (IA[AW-1:0]),
    .raddr_d (DA[AW-1:0]),
    .rdata_i (ram_i),
    .rdata_d (ram_d)
  );

  assign ID       = ia_ok ? ram_i : ERR_DATA;
  assign rdata    = da_ok ? ram_d : ERR_DATA;
  assign DD       = (state == RUN && RW) ? rdata : 16'hzzzz;
  assign CPU_RST  = cpu_rst;
  assign LD_WORDS = ptr;
  assign ERR      = err;

endmodule
